// File: rtl/vc_fifo_pkg.sv
// Shared NoC buffer parameters and the width helper used by vc_fifo and its banks.
// Imported by vc_fifo, vc_fifo_bank and the router/NI blocks that size ports from them.
package vc_fifo_pkg;

  localparam int FLIT_W        = 64;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_NUM_VC    = 2;
  localparam int DEF_AF_THRESH = 3;

  // Select fields stay at least one bit wide even for a single VC.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_fifo_bank.sv
// One virtual channel's circular buffer: storage, pointers, occupancy and status flags.
// Sticky overflow/underflow tracking exists only when VC_FIFO_ERR_EN is defined.
module vc_fifo_bank
  import vc_fifo_pkg::*;
#(
  parameter  int WIDTH     = FLIT_W,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int AF_THRESH = DEF_AF_THRESH,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_acc,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_acc;

  // Both accepts are judged on the pre-edge flags, so a full bank can still
  // drain while rejecting the write, and an empty bank can fill while rejecting the read.
  assign wr_acc      = wr_req && !full;
  assign rd_acc      = rd_req && !empty;
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_W'(AF_THRESH));
  assign rd_data     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef VC_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req && full)  overflow  <= 1'b1;
      if (rd_req && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: rtl/vc_fifo.sv
// Multi-VC flit buffer: NUM_VC independent banks behind one shared write port and one registered read port.
// Define VC_FIFO_ERR_EN to enable the sticky overflow/underflow flags (tied low otherwise).
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter  int WIDTH     = FLIT_W,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int NUM_VC    = DEF_NUM_VC,
  parameter  int AF_THRESH = DEF_AF_THRESH,
  localparam int VC_W      = clog2_min1(NUM_VC),
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [VC_W-1:0]         write_vc,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    read_en,
  input  logic [VC_W-1:0]         read_vc,
  output logic [WIDTH-1:0]        data_out,
  output logic                    data_valid,
  output logic [NUM_VC-1:0]       full,
  output logic [NUM_VC-1:0]       empty,
  output logic [NUM_VC-1:0]       almost_full,
  output logic [NUM_VC*CNT_W-1:0] count,
  output logic [NUM_VC-1:0]       overflow,
  output logic [NUM_VC-1:0]       underflow
);

  // Handshake: write_en/read_en are requests with no ready; the sender must consult
  // full/empty (its credits) beforehand. A request is taken at the edge only if its
  // VC's pre-edge flag allows it; a taken read appears on data_out with data_valid
  // high for exactly the cycle after that edge. Out-of-range VC selects match no bank.
  logic [WIDTH-1:0]  bank_rd_data [NUM_VC];
  logic [NUM_VC-1:0] bank_rd_acc;
  logic [WIDTH-1:0]  rd_sel;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_bank
    vc_fifo_bank #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
    ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .wr_req      (write_en && (write_vc == VC_W'(g))),
      .wr_data     (data_in),
      .rd_req      (read_en && (read_vc == VC_W'(g))),
      .rd_data     (bank_rd_data[g]),
      .rd_acc      (bank_rd_acc[g]),
      .count       (count[g*CNT_W +: CNT_W]),
      .full        (full[g]),
      .empty       (empty[g]),
      .almost_full (almost_full[g]),
      .overflow    (overflow[g]),
      .underflow   (underflow[g])
    );
  end

  always_comb begin
    rd_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (bank_rd_acc[v]) rd_sel = bank_rd_data[v];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= |bank_rd_acc;
      if (|bank_rd_acc) data_out <= rd_sel;
    end
  end

endmodule

// File: tb/tb_vc_fifo.sv
// Scoreboard bench for vc_fifo: per-VC queue model predicts reads and flags; a negedge monitor compares.
// Honours VC_FIFO_ERR_EN the same way as the design when predicting overflow/underflow.
module tb_vc_fifo;

  localparam int W  = 64;
  localparam int D  = 4;
  localparam int NV = 2;
  localparam int AF = 3;
  localparam int CW = $clog2(D) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           write_en;
  logic [0:0]     write_vc;
  logic [W-1:0]   data_in;
  logic           read_en;
  logic [0:0]     read_vc;
  logic [W-1:0]   data_out;
  logic           data_valid;
  logic [NV-1:0]  full;
  logic [NV-1:0]  empty;
  logic [NV-1:0]  almost_full;
  logic [NV*CW-1:0] count;
  logic [NV-1:0]  overflow;
  logic [NV-1:0]  underflow;

  vc_fifo #(.WIDTH(W), .DEPTH(D), .NUM_VC(NV), .AF_THRESH(AF)) dut (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .write_vc    (write_vc),
    .data_in     (data_in),
    .read_en     (read_en),
    .read_vc     (read_vc),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model and scoreboard state
  logic [W-1:0] model_q [NV][$];
  logic [W-1:0] exp_q[$];
  logic         stage_valid = 1'b0;
  logic [W-1:0] stage_data  = '0;
  bit           exp_ovf [NV];
  bit           exp_udf [NV];
  int           snap_cnt [NV];
  bit           snap_ovf [NV];
  bit           snap_udf [NV];
  bit           armed    = 1'b0;
  bit           rst_seen = 1'b0;
  logic [W-1:0] exp_last = '0;
  int           checks   = 0;
  int           failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: predicts this cycle's outcome from pre-edge model occupancy, then clocks.
  task automatic cyc(input bit we, input int wv, input logic [W-1:0] d,
                     input bit re, input int rv);
    int wsz;
    int rsz;
    reset    = 1'b0;
    write_en = we;
    write_vc = 1'(wv);
    data_in  = d;
    read_en  = re;
    read_vc  = 1'(rv);
    stage_valid = 1'b0;
    wsz = model_q[wv].size();
    rsz = model_q[rv].size();
    if (re) begin
      if (rsz > 0) begin
        stage_valid = 1'b1;
        stage_data  = model_q[rv].pop_front();
      end else begin
        exp_udf[rv] = 1'b1;
      end
    end
    if (we) begin
      if (wsz < D) model_q[wv].push_back(d);
      else         exp_ovf[wv] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic do_reset(input int n);
    reset       = 1'b1;
    write_en    = 1'b0;
    read_en     = 1'b0;
    write_vc    = '0;
    read_vc     = '0;
    data_in     = '0;
    stage_valid = 1'b0;
    for (int v = 0; v < NV; v++) begin
      model_q[v].delete();
      exp_ovf[v] = 1'b0;
      exp_udf[v] = 1'b0;
    end
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  // At each edge the model already holds the post-edge state; capture it for the monitor.
  always @(posedge clk) begin
    rst_seen = reset;
    if (reset) begin
      exp_q.delete();
      armed = 1'b1;
    end else if (stage_valid) begin
      exp_q.push_back(stage_data);
    end
    for (int v = 0; v < NV; v++) begin
      snap_cnt[v] = model_q[v].size();
      snap_ovf[v] = exp_ovf[v];
      snap_udf[v] = exp_udf[v];
    end
  end

  // Monitor: compares outputs mid-cycle against the scoreboard and snapshot.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (armed) begin
      if (rst_seen) exp_last = '0;
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_valid: got data_valid=1 data_out=%h expected data_valid=0 at %0t",
                   data_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("read_data", data_out, e);
          exp_last = e;
        end
      end else begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_valid: got data_valid=0 expected data_valid=1 data %h at %0t",
                   e, $time);
        end
        chk("data_hold", data_out, exp_last);
      end
      for (int v = 0; v < NV; v++) begin
        chk($sformatf("count[%0d]", v), W'(count[v*CW +: CW]), W'(snap_cnt[v]));
        chk($sformatf("full[%0d]", v), W'(full[v]), W'(snap_cnt[v] == D));
        chk($sformatf("empty[%0d]", v), W'(empty[v]), W'(snap_cnt[v] == 0));
        chk($sformatf("almost_full[%0d]", v), W'(almost_full[v]), W'(snap_cnt[v] >= AF));
`ifdef VC_FIFO_ERR_EN
        chk($sformatf("overflow[%0d]", v), W'(overflow[v]), W'(snap_ovf[v]));
        chk($sformatf("underflow[%0d]", v), W'(underflow[v]), W'(snap_udf[v]));
`else
        chk($sformatf("overflow[%0d]", v), W'(overflow[v]), '0);
        chk($sformatf("underflow[%0d]", v), W'(underflow[v]), '0);
`endif
      end
    end
  end

  initial begin
    logic [W-1:0] fill_pat [4];
    int wp;
    int rp;
    fill_pat[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    fill_pat[1] = 64'hA5A5_A5A5_A5A5_A1A5;
    fill_pat[2] = 64'hA5A5_A5A5_A5A5_A4A5;
    fill_pat[3] = 64'h35A5_A5A5_A5A5_A5A5;

    reset = 1'b1; write_en = 1'b0; read_en = 1'b0;
    write_vc = '0; read_vc = '0; data_in = '0;
    #1;
    do_reset(2);
    idle(1);

    // Fill VC0 to full, then drain past empty.
    for (int i = 0; i < 4; i++) cyc(1'b1, 0, fill_pat[i], 1'b0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, '0, 1'b1, 0);
    idle(1);

    // Interleaved VCs.
    cyc(1'b1, 1, 64'h1, 1'b0, 0);
    cyc(1'b1, 0, 64'h2, 1'b0, 0);
    cyc(1'b0, 0, '0, 1'b1, 1);
    idle(1);

    // Full VC0 with simultaneous write+read on it, plus an extra write when full.
    for (int i = 0; i < 3; i++) cyc(1'b1, 0, 64'h10 + W'(i), 1'b0, 0);
    cyc(1'b1, 0, 64'hDEAD, 1'b1, 0);
    cyc(1'b1, 0, 64'hBEEF, 1'b0, 0);
    cyc(1'b1, 0, 64'hCAFE, 1'b0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, '0, 1'b1, 0);

    // Same-cycle write+read on empty VC1, then wrap-around with incrementing data.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1, 64'h100 + W'(i), 1'b1, 1);
    cyc(1'b0, 0, '0, 1'b1, 1);
    idle(1);

    // Reset in the middle of a burst.
    cyc(1'b1, 0, 64'h77, 1'b0, 0);
    cyc(1'b1, 1, 64'h88, 1'b0, 0);
    cyc(1'b1, 0, 64'h99, 1'b1, 0);
    do_reset(1);
    idle(2);

    // Randomized traffic with shifting write/read bias to hit full and empty often.
    for (int p = 0; p < 6; p++) begin
      wp = (p % 2 == 0) ? 75 : 30;
      rp = (p % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 80; i++) begin
        cyc(($urandom_range(0, 99) < wp), int'($urandom_range(0, NV - 1)), {$urandom, $urandom},
            ($urandom_range(0, 99) < rp), int'($urandom_range(0, NV - 1)));
      end
    end
    idle(3);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
